// File: rtl/sd_bram_pkg.sv
// ---------------------------------------------------------------------------
// sd_bram_pkg
// Shared definitions for the SD sector block-RAM streamer: RAM geometry,
// transfer direction encodings and the sequencer state type.
// ---------------------------------------------------------------------------
package sd_bram_pkg;

  localparam int unsigned RAM_DEPTH      = 66;
  localparam int unsigned RAM_ADDR_W     = 7;
  localparam int unsigned RAM_DATA_W     = 64;
  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // Direction as sampled with start
  localparam logic DIR_RD = 1'b0;  // RAM -> byte stream
  localparam logic DIR_WR = 1'b1;  // byte stream -> RAM

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_LOAD,
    ST_RD_SHIFT,
    ST_WR_COLLECT,
    ST_WR_COMMIT,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/sd_word_byte_shifter.sv
// ---------------------------------------------------------------------------
// sd_word_byte_shifter
// 64-bit word <-> byte shift register with a byte counter.
//   clk, reset    : clock, synchronous active-high reset
//   load_i        : parallel load of load_data_i, byte counter cleared
//   load_data_i   : word to load (RAM read data)
//   clear_i       : clear byte counter only
//   shift_out_i   : shift left one byte (byte_o presents the next MSB byte)
//   shift_in_i    : shift byte_i into the LSB byte
//   byte_i        : incoming byte
//   byte_o        : current MSB byte of the register
//   packed_o      : register value including byte_i, as it would be after a
//                   shift-in this cycle
//   last_byte_o   : counter is on the final byte of the word
// Priority: load > clear > shift_out > shift_in.
// ---------------------------------------------------------------------------
module sd_word_byte_shifter
  import sd_bram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [RAM_DATA_W-1:0] load_data_i,
  input  logic                  clear_i,
  input  logic                  shift_out_i,
  input  logic                  shift_in_i,
  input  logic [7:0]            byte_i,
  output logic [7:0]            byte_o,
  output logic [RAM_DATA_W-1:0] packed_o,
  output logic                  last_byte_o
);

  typedef logic [BYTE_CNT_W-1:0] cnt_t;

  logic [RAM_DATA_W-1:0] shreg_q, shreg_d;
  cnt_t                  cnt_q, cnt_d;

  assign byte_o      = shreg_q[RAM_DATA_W-1 -: 8];
  assign packed_o    = {shreg_q[RAM_DATA_W-9:0], byte_i};
  assign last_byte_o = (cnt_q == cnt_t'(BYTES_PER_WORD - 1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_data_i;
      cnt_d   = '0;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (shift_out_i) begin
      shreg_d = {shreg_q[RAM_DATA_W-9:0], 8'h00};
      cnt_d   = cnt_q + cnt_t'(1);
    end else if (shift_in_i) begin
      shreg_d = packed_o;
      cnt_d   = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_bram_sector_streamer.sv
// ---------------------------------------------------------------------------
// sd_bram_sector_streamer
// Drives port B of the 66 x 64 SD sector RAM and converts between RAM words
// and the 8-bit byte stream of the SD data-line logic.
//   clk, reset          : clock, synchronous active-high reset
//   start/dir/base_addr/num_words : command, sampled in IDLE only
//   abort               : terminate the running transfer (err reported)
//   busy, done, err     : status; err is valid with done and held until the
//                         next accepted start
//   tx_data/tx_valid/tx_ready : byte stream out (read mode), MSB byte first
//   rx_data/rx_valid/rx_ready : byte stream in (write mode), first byte is MSB
//   bram_addr/bram_wr/bram_din : registered RAM port controls
//   bram_dout           : RAM read data, one cycle after bram_addr
// ---------------------------------------------------------------------------
module sd_bram_sector_streamer
  import sd_bram_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     num_words,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic                  bram_wr,
  output logic [RAM_DATA_W-1:0] bram_din,
  input  logic [RAM_DATA_W-1:0] bram_dout
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     words_q, words_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [RAM_DATA_W-1:0] din_q, din_d;

  logic                  sh_load, sh_clear, sh_out, sh_in;
  logic [7:0]            sh_byte;
  logic [RAM_DATA_W-1:0] sh_packed;
  logic                  sh_last;

  logic [SUM_W-1:0]      end_addr;
  logic                  cmd_bad;
  logic                  last_word;
  logic                  tx_fire, rx_fire;

  // One bit wider than the address so base+count cannot wrap past DEPTH
  assign end_addr  = SUM_W'(base_addr) + SUM_W'(num_words);
  assign cmd_bad   = (num_words == '0) || (end_addr > SUM_W'(DEPTH));
  assign last_word = (words_q == ADDR_W'(1));

  // Handshakes are gated by abort so an abort always beats a same-cycle
  // byte transfer, including the last byte of a word.
  assign tx_valid = (state_q == ST_RD_SHIFT) && !abort;
  assign rx_ready = (state_q == ST_WR_COLLECT) && !abort;
  assign tx_fire  = tx_valid && tx_ready;
  assign rx_fire  = rx_valid && rx_ready;

  assign tx_data   = sh_byte;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done      = (state_q == ST_FINISH);
  assign err       = err_q;
  assign bram_addr = addr_q;
  assign bram_wr   = wr_q;
  assign bram_din  = din_q;

  sd_word_byte_shifter u_shifter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (sh_load),
    .load_data_i (bram_dout),
    .clear_i     (sh_clear),
    .shift_out_i (sh_out),
    .shift_in_i  (sh_in),
    .byte_i      (rx_data),
    .byte_o      (sh_byte),
    .packed_o    (sh_packed),
    .last_byte_o (sh_last)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    words_d  = words_q;
    err_d    = err_q;
    wr_d     = 1'b0;
    din_d    = din_q;
    sh_load  = 1'b0;
    sh_clear = 1'b0;
    sh_out   = 1'b0;
    sh_in    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          sh_clear = 1'b1;
          if (cmd_bad) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            addr_d  = base_addr;
            words_d = num_words;
            state_d = (dir == DIR_WR) ? ST_WR_COLLECT : ST_RD_ADDR;
          end
        end
      end

      ST_RD_ADDR: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RD_LOAD;
        end
      end

      ST_RD_LOAD: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          sh_load = 1'b1;
          state_d = ST_RD_SHIFT;
        end
      end

      ST_RD_SHIFT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (tx_fire) begin
          sh_out = 1'b1;
          if (sh_last) begin
            words_d = words_q - ADDR_W'(1);
            if (last_word) begin
              state_d = ST_FINISH;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_RD_ADDR;
            end
          end
        end
      end

      ST_WR_COLLECT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (rx_fire) begin
          sh_in = 1'b1;
          if (sh_last) begin
            din_d   = sh_packed;
            wr_d    = 1'b1;
            state_d = ST_WR_COMMIT;
          end
        end
      end

      ST_WR_COMMIT: begin
        // The write strobe is already on the port this cycle; abort only
        // prevents further words.
        words_d = words_q - ADDR_W'(1);
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (last_word) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_WR_COLLECT;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_sd_bram_sector_streamer.sv
// ---------------------------------------------------------------------------
// tb_sd_bram_sector_streamer
// Self-checking bench: a behavioural 66 x 64 synchronous RAM on port B,
// expected tx bytes and RAM writes queued when commands are issued and
// compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_sd_bram_sector_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [6:0]  base_addr;
  logic [6:0]  num_words;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [6:0]  bram_addr;
  logic        bram_wr;
  logic [63:0] bram_din;
  logic [63:0] bram_dout;

  always #5 clk = ~clk;

  sd_bram_sector_streamer #(
    .ADDR_W (7),
    .DEPTH  (66)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .base_addr (base_addr),
    .num_words (num_words),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .bram_addr (bram_addr),
    .bram_wr   (bram_wr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic [63:0] data;
  } wr_exp_t;

  logic [7:0]   exp_tx[$];
  wr_exp_t      exp_wr[$];
  logic [63:0]  mem [0:65];

  int unsigned n_checks      = 0;
  int unsigned n_fail        = 0;
  int unsigned tx_acc        = 0;
  int unsigned tx_valid_seen = 0;
  int unsigned wr_seen       = 0;
  int unsigned extra         = 0;

  logic [7:0]   mon_b;
  wr_exp_t      mon_w;

  function automatic logic [63:0] word_pat(input int unsigned a);
    if (a == 0) return 64'h0011223344556677;
    if (a == 1) return 64'h8899AABBCCDDEEFF;
    return {8{8'(a)}} ^ 64'h5A00_0000_0000_00A5;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural port-B RAM: synchronous read, contents restored on reset
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 66; i++) mem[i] <= word_pat(i);
    end else if (bram_wr && bram_addr < 7'd66) begin
      mem[bram_addr] <= bram_din;
    end
    bram_dout <= (bram_addr < 7'd66) ? mem[bram_addr] : 64'h0;
  end

  // Output monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_valid) tx_valid_seen++;
    if (tx_valid && tx_ready) begin
      tx_acc++;
      if (exp_tx.size() > 0) begin
        mon_b = exp_tx.pop_front();
        check_eq("tx_byte", tx_data, mon_b);
      end else begin
        extra++;
      end
    end
    if (bram_wr) begin
      wr_seen++;
      if (exp_wr.size() > 0) begin
        mon_w = exp_wr.pop_front();
        check_eq("wr_addr", bram_addr, mon_w.addr);
        check_eq("wr_data", bram_din, mon_w.data);
      end else begin
        extra++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read_word(input logic [63:0] w);
    for (int b = 0; b < 8; b++) exp_tx.push_back(w[63-8*b -: 8]);
  endtask

  task automatic start_cmd(input logic d, input logic [6:0] base, input logic [6:0] num);
    dir       = d;
    base_addr = base;
    num_words = num;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Waits (bounded) for done; reports cycles waited and busy cycles seen
  task automatic wait_done(output int unsigned cyc, output int unsigned busy_cyc,
                           output logic err_seen);
    cyc      = 0;
    busy_cyc = 0;
    while (!done && cyc < 300) begin
      if (busy) busy_cyc++;
      cyc++;
      tick();
    end
    check_eq("done_seen", done, 1'b1);
    check_eq("busy_at_done", busy, 1'b0);
    err_seen = err;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int unsigned n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("rx_ready_wait", rx_ready, 1'b1);
    tick();
    rx_valid = 1'b0;
    if (gap) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, summary not produced");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned cyc, bcyc, n, tx0, v0, w0;
    logic        e;
    logic [63:0] w;
    logic [7:0]  b3;

    reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; num_words = '0;
    abort = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_tx_valid", tx_valid, 1'b0);
    check_eq("rst_rx_ready", rx_ready, 1'b0);
    check_eq("rst_bram_wr", bram_wr, 1'b0);
    check_eq("rst_bram_addr", bram_addr, 7'd0);
    check_eq("rst_bram_din", bram_din, 64'd0);
    check_eq("rst_tx_data", tx_data, 8'd0);
    reset = 1'b0;
    tick();

    // Two-word read, full throughput
    push_read_word(word_pat(0));
    push_read_word(word_pat(1));
    tx_ready = 1'b1;
    tx0 = tx_acc;
    start_cmd(1'b0, 7'd0, 7'd2);
    wait_done(cyc, bcyc, e);
    check_eq("rd2_busy_cycles", bcyc, 20);
    check_eq("rd2_err", e, 1'b0);
    check_eq("rd2_bytes", tx_acc - tx0, 16);

    // Single-word write with gapped rx_valid
    exp_wr.push_back('{addr: 7'd5, data: 64'hA0A1A2A3A4A5A6A7});
    w0 = wr_seen;
    start_cmd(1'b1, 7'd5, 7'd1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b1);
    wait_done(cyc, bcyc, e);
    check_eq("wr1_count", wr_seen - w0, 1);
    check_eq("wr1_err", e, 1'b0);

    // Read with a 4-cycle stall on byte 3
    w = word_pat(20);
    b3 = w[39:32];
    push_read_word(w);
    tx_ready = 1'b1;
    tx0 = tx_acc;
    start_cmd(1'b0, 7'd20, 7'd1);
    n = 0;
    while (tx_acc - tx0 != 3 && n < 50) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_valid", tx_valid, 1'b1);
      check_eq("stall_data", tx_data, b3);
      tick();
    end
    tx_ready = 1'b1;
    wait_done(cyc, bcyc, e);
    check_eq("stall_err", e, 1'b0);
    check_eq("stall_bytes", tx_acc - tx0, 8);

    // Illegal commands: past the end, and zero length
    v0 = tx_valid_seen;
    w0 = wr_seen;
    start_cmd(1'b0, 7'd60, 7'd7);
    wait_done(cyc, bcyc, e);
    check_eq("ill_range_lat", cyc <= 2, 1'b1);
    check_eq("ill_range_busy", bcyc, 0);
    check_eq("ill_range_err", e, 1'b1);
    start_cmd(1'b1, 7'd3, 7'd0);
    wait_done(cyc, bcyc, e);
    check_eq("ill_zero_lat", cyc <= 2, 1'b1);
    check_eq("ill_zero_err", e, 1'b1);
    check_eq("ill_tx_valid", tx_valid_seen - v0, 0);
    check_eq("ill_wr", wr_seen - w0, 0);

    // Two-word write aborted after the 4th byte of word 1
    exp_wr.push_back('{addr: 7'd10, data: 64'h1011121314151617});
    w0 = wr_seen;
    start_cmd(1'b1, 7'd10, 7'd2);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i), 1'b0);
    abort    = 1'b1;
    rx_data  = 8'h24;
    rx_valid = 1'b1;
    tick();
    abort    = 1'b0;
    rx_valid = 1'b0;
    check_eq("abort_rx_ready", rx_ready, 1'b0);
    check_eq("abort_done", done, 1'b1);
    check_eq("abort_err", err, 1'b1);
    repeat (3) tick();
    check_eq("abort_wr_count", wr_seen - w0, 1);

    // Reset in the middle of a read, at byte 5
    push_read_word(word_pat(30));
    push_read_word(word_pat(31));
    tx_ready = 1'b1;
    tx0 = tx_acc;
    start_cmd(1'b0, 7'd30, 7'd2);
    n = 0;
    while (tx_acc - tx0 != 5 && n < 50) begin
      tick();
      n++;
    end
    reset    = 1'b1;
    tx_ready = 1'b0;
    exp_tx.delete();
    tick();
    check_eq("rstmid_ctrl", {busy, done, err, tx_valid, rx_ready, bram_wr}, 6'd0);
    check_eq("rstmid_addr", bram_addr, 7'd0);
    check_eq("rstmid_tx_data", tx_data, 8'd0);
    check_eq("rstmid_din", bram_din, 64'd0);
    reset = 1'b0;
    w0 = wr_seen;
    for (int i = 0; i < 3; i++) begin
      check_eq("rstmid_no_done", done, 1'b0);
      check_eq("rstmid_idle", busy, 1'b0);
      tick();
    end
    check_eq("rstmid_no_wr", wr_seen - w0, 0);

    // Normal operation afterwards, using the highest legal address
    push_read_word(word_pat(65));
    tx_ready = 1'b1;
    tx0 = tx_acc;
    start_cmd(1'b0, 7'd65, 7'd1);
    wait_done(cyc, bcyc, e);
    check_eq("last_addr_busy", bcyc, 10);
    check_eq("last_addr_err", e, 1'b0);
    check_eq("last_addr_bytes", tx_acc - tx0, 8);

    repeat (2) tick();
    check_eq("unexpected_events", extra, 0);
    check_eq("tx_queue_left", exp_tx.size(), 0);
    check_eq("wr_queue_left", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
